digit_shift_receiver: RTL and testbench

DIGIT_SHIFT_RECEIVER -- requirements
Module: digit_shift_receiver

---
 rtl/digit_shift_receiver.sv | 138 +++++++++++++
 tb/tb_digit_shift_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_shift_receiver.sv
// Serial seven-segment frame receiver: synchronizes an external shift clock,
// latch strobe and data line, then decodes each latched digit to BCD.
module digit_shift_receiver #(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned BITS_PER_DIGIT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 ext_clk,
    input  logic                                 ext_latch,
    input  logic                                 serial_in,
    output logic [BITS_PER_DIGIT*NUM_DIGITS-1:0] digit_segs,
    output logic [4*NUM_DIGITS-1:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]                digit_dp,
    output logic [NUM_DIGITS-1:0]                digit_blank,
    output logic [NUM_DIGITS-1:0]                decode_err,
    output logic                                 frame_valid,
    output logic                                 frame_err
);

    localparam int unsigned FRAME_BITS = BITS_PER_DIGIT * NUM_DIGITS;
    localparam int unsigned CNT_W      = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]            clk_sync;
    logic [1:0]            latch_sync;
    logic [1:0]            data_sync;
    logic                  clk_dly;
    logic                  latch_dly;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  shift_c;
    logic                  latch_c;
    logic [FRAME_BITS-1:0] shift_next_c;
    logic [CNT_W-1:0]      cnt_next_c;
    logic [5:0]            dec_c;
    logic [4*NUM_DIGITS-1:0] bcd_c;
    logic [NUM_DIGITS-1:0] dp_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [NUM_DIGITS-1:0] err_c;

    // Segment pattern to {blank, err, bcd}; dp is excluded by the caller.
    function automatic logic [5:0] decode_led(input logic [6:0] led);
        case (led)
            7'h3F:        return {2'b00, 4'd0};
            7'h06:        return {2'b00, 4'd1};
            7'h5B:        return {2'b00, 4'd2};
            7'h4F:        return {2'b00, 4'd3};
            7'h66:        return {2'b00, 4'd4};
            7'h6D:        return {2'b00, 4'd5};
            7'h7D, 7'h7C: return {2'b00, 4'd6};
            7'h07:        return {2'b00, 4'd7};
            7'h7F:        return {2'b00, 4'd8};
            7'h6F, 7'h67: return {2'b00, 4'd9};
            7'h00:        return {2'b10, 4'hF};
            default:      return {2'b01, 4'hF};
        endcase
    endfunction

    assign shift_c = en & clk_sync[1] & ~clk_dly;
    assign latch_c = en & latch_sync[1] & ~latch_dly;

    // A shift in the latch cycle lands first so the latch sees that bit.
    always_comb begin
        shift_next_c = shift_q;
        cnt_next_c   = cnt_q;
        if (shift_c) begin
            shift_next_c = {shift_q[FRAME_BITS-2:0], data_sync[1]};
            if (cnt_q != CNT_MAX) begin
                cnt_next_c = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dec_c   = '0;
        bcd_c   = '0;
        dp_c    = '0;
        blank_c = '0;
        err_c   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dec_c          = decode_led(shift_next_c[BITS_PER_DIGIT*k +: 7]);
            bcd_c[4*k +: 4] = dec_c[3:0];
            err_c[k]       = dec_c[4];
            blank_c[k]     = dec_c[5];
            dp_c[k]        = shift_next_c[BITS_PER_DIGIT*k + 7];
        end
    end

    // Synchronizers and edge flops run regardless of en so re-enabling never
    // produces a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= '0;
            latch_sync <= '0;
            data_sync  <= '0;
            clk_dly    <= 1'b0;
            latch_dly  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ext_clk};
            latch_sync <= {latch_sync[0], ext_latch};
            data_sync  <= {data_sync[0], serial_in};
            clk_dly    <= clk_sync[1];
            latch_dly  <= latch_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            digit_segs  <= '0;
            digit_bcd   <= '1;
            digit_dp    <= '0;
            digit_blank <= '1;
            decode_err  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            shift_q     <= shift_next_c;
            frame_valid <= latch_c;
            if (latch_c) begin
                cnt_q       <= '0;
                digit_segs  <= shift_next_c;
                digit_bcd   <= bcd_c;
                digit_dp    <= dp_c;
                digit_blank <= blank_c;
                decode_err  <= err_c;
                frame_err   <= (32'(cnt_next_c) != FRAME_BITS);
            end else begin
                cnt_q <= cnt_next_c;
            end
        end
    end

endmodule

// File: tb/tb_digit_shift_receiver.sv
// Scoreboard bench for digit_shift_receiver: a bit-level model predicts each
// latched frame; a monitor pops predictions whenever frame_valid fires.
module tb_digit_shift_receiver;

    localparam int unsigned ND = 6;
    localparam int unsigned FB = 8 * ND;

    typedef struct packed {
        logic [FB-1:0]   segs;
        logic [4*ND-1:0] bcd;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   blank;
        logic [ND-1:0]   derr;
        logic            ferr;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic ext_clk = 1'b0;
    logic ext_latch = 1'b0;
    logic serial_in = 1'b0;
    logic [FB-1:0]   digit_segs;
    logic [4*ND-1:0] digit_bcd;
    logic [ND-1:0]   digit_dp;
    logic [ND-1:0]   digit_blank;
    logic [ND-1:0]   decode_err;
    logic            frame_valid;
    logic            frame_err;

    int total = 0;
    int bad = 0;

    frame_t        exp_q[$];
    frame_t        last_exp;
    logic [FB-1:0] model_sr = '0;
    int            model_cnt = 0;

    digit_shift_receiver #(.NUM_DIGITS(ND), .BITS_PER_DIGIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ext_clk(ext_clk), .ext_latch(ext_latch),
        .serial_in(serial_in), .digit_segs(digit_segs), .digit_bcd(digit_bcd),
        .digit_dp(digit_dp), .digit_blank(digit_blank), .decode_err(decode_err),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference decoder: table lookup, {blank, err, bcd}.
    function automatic logic [5:0] ref_decode(input logic [6:0] led);
        logic [6:0] pats [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                  7'h7D, 7'h7C, 7'h07, 7'h7F, 7'h6F, 7'h67};
        logic [3:0] vals [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                  4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9};
        if (led == 7'h00) return 6'b10_1111;
        for (int i = 0; i < 12; i++) begin
            if (pats[i] == led) return {2'b00, vals[i]};
        end
        return 6'b01_1111;
    endfunction

    function automatic frame_t build_frame(input logic [FB-1:0] sr, input int cnt);
        frame_t f;
        logic [7:0] b;
        logic [5:0] d;
        f.segs = sr;
        f.ferr = (cnt != FB);
        f.bcd = '0; f.dp = '0; f.blank = '0; f.derr = '0;
        for (int k = 0; k < ND; k++) begin
            b = sr[8*k +: 8];
            d = ref_decode(b[6:0]);
            f.bcd[4*k +: 4] = d[3:0];
            f.derr[k]       = d[4];
            f.blank[k]      = d[5];
            f.dp[k]         = b[7];
        end
        return f;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        frame_t e;
        frame_t g;
        if (rst_n && frame_valid) begin
            total++;
            g = {digit_segs, digit_bcd, digit_dp, digit_blank, decode_err, frame_err};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame_valid got segs=%h bcd=%h", digit_segs, digit_bcd);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL frame got segs=%h bcd=%h dp=%b blank=%b derr=%b ferr=%b want segs=%h bcd=%h dp=%b blank=%b derr=%b ferr=%b",
                             g.segs, g.bcd, g.dp, g.blank, g.derr, g.ferr,
                             e.segs, e.bcd, e.dp, e.blank, e.derr, e.ferr);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s frame_valid timeout pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_expected();
        last_exp = build_frame(model_sr, model_cnt);
        exp_q.push_back(last_exp);
        model_cnt = 0;
    endtask

    task automatic send_bit(input logic b, input logic with_latch);
        @(negedge clk);
        serial_in = b;
        repeat (3) @(negedge clk);
        if (en) begin
            model_sr = {model_sr[FB-2:0], b};
            if (model_cnt < 63) model_cnt++;
            if (with_latch) push_expected();
        end
        ext_clk = 1'b1;
        if (with_latch) ext_latch = 1'b1;
        repeat (4) @(negedge clk);
        ext_clk = 1'b0;
        ext_latch = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d5, input logic [7:0] d4, input logic [7:0] d3,
                              input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
        send_byte(d5); send_byte(d4); send_byte(d3);
        send_byte(d2); send_byte(d1); send_byte(d0);
    endtask

    task automatic pulse_latch(input string name);
        @(negedge clk);
        if (en) push_expected();
        ext_latch = 1'b1;
        repeat (4) @(negedge clk);
        ext_latch = 1'b0;
        repeat (4) @(negedge clk);
        wait_drain(name);
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({digit_segs, digit_dp, decode_err, frame_valid, frame_err} !== '0) begin
            bad++;
            $display("FAIL %s_zero got segs=%h dp=%b derr=%b fv=%b ferr=%b want all 0",
                     name, digit_segs, digit_dp, decode_err, frame_valid, frame_err);
        end
        total++;
        if (digit_bcd !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL %s_bcd got %h want ffffff", name, digit_bcd);
        end
        total++;
        if (digit_blank !== 6'h3F) begin
            bad++;
            $display("FAIL %s_blank got %b want 111111", name, digit_blank);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        send_frame(8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D);
        pulse_latch("full_frame");
        total++;
        if ({digit_bcd, frame_err, decode_err} !== {24'h123456, 1'b0, 6'h00}) begin
            bad++;
            $display("FAIL full_frame_bcd got bcd=%h ferr=%b derr=%b want 123456/0/000000",
                     digit_bcd, frame_err, decode_err);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) send_bit(1'(i % 2), 1'b0);
        total++;
        if ({digit_segs, digit_bcd, digit_dp, digit_blank, decode_err, frame_err} !== last_exp) begin
            bad++;
            $display("FAIL hold got segs=%h bcd=%h want segs=%h bcd=%h",
                     digit_segs, digit_bcd, last_exp.segs, last_exp.bcd);
        end
        pulse_latch("hold_flush");
    endtask

    task automatic test_short_and_long();
        for (int i = 0; i < 47; i++) send_bit(1'($urandom_range(1)), 1'b0);
        pulse_latch("short47");
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL short47_ferr got %b want 1", frame_err);
        end
        for (int i = 0; i < 70; i++) send_bit(1'($urandom_range(1)), 1'b0);
        pulse_latch("long70");
        total++;
        if (frame_err !== 1'b1) begin
            bad++;
            $display("FAIL long70_ferr got %b want 1", frame_err);
        end
    endtask

    task automatic test_decode_table();
        send_frame(8'h7C, 8'h67, 8'h3F, 8'h07, 8'h7F, 8'h00);
        pulse_latch("decode_a");
        send_frame(8'h6F, 8'h5B, 8'h4F, 8'hFF, 8'h49, 8'h80);
        pulse_latch("decode_b");
        total++;
        if ({digit_dp[0], digit_blank[0], digit_bcd[3:0], decode_err[1], decode_err[0]}
                !== {1'b1, 1'b1, 4'hF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL dp_blank got dp0=%b blank0=%b bcd0=%h derr1=%b derr0=%b want 1 1 f 1 0",
                     digit_dp[0], digit_blank[0], digit_bcd[3:0], decode_err[1], decode_err[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 47; i++) send_bit(1'($urandom_range(1)), 1'b0);
        send_bit(1'b1, 1'b1);
        wait_drain("same_cycle");
        total++;
        if (frame_err !== 1'b0 || digit_segs[0] !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle got ferr=%b bit0=%b want 0 1", frame_err, digit_segs[0]);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_sr = '0;
        model_cnt = 0;
        repeat (3) @(negedge clk);
        check_reset_values("mid_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D);
        pulse_latch("after_reset");
        total++;
        if ({digit_bcd, frame_err} !== {24'h012345, 1'b0}) begin
            bad++;
            $display("FAIL after_reset got bcd=%h ferr=%b want 012345 0", digit_bcd, frame_err);
        end
    endtask

    task automatic test_enable();
        int fv_seen = 0;
        send_frame(8'h7F, 8'h6F, 8'h07, 8'h7D, 8'h66, 8'h06);
        pulse_latch("pre_enable");
        en = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        ext_latch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_valid) fv_seen++;
        end
        ext_latch = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (fv_seen !== 0) begin
            bad++;
            $display("FAIL en_off_latch frame_valid cycles=%0d want 0", fv_seen);
        end
        total++;
        if ({digit_segs, digit_bcd, digit_dp, digit_blank, decode_err, frame_err} !== last_exp) begin
            bad++;
            $display("FAIL en_off_hold got segs=%h bcd=%h want segs=%h bcd=%h",
                     digit_segs, digit_bcd, last_exp.segs, last_exp.bcd);
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
        pulse_latch("en_restore");
        total++;
        if ({digit_bcd, frame_err} !== {24'h897641, 1'b1}) begin
            bad++;
            $display("FAIL en_restore got bcd=%h ferr=%b want 897641 1", digit_bcd, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_hold();
        test_short_and_long();
        test_decode_table();
        test_back_to_back();
        test_reset_midframe();
        test_enable();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
